// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: shared defaults and per-bit FSM encoding for the switch debouncer.
package switch_debouncer_pkg;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_CNT_W = 16;
    localparam int SW_W = 4;
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_e;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser, stability counter and FSM for one switch.
// changed is combinational and marks the edge on which clean takes the new value.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic changed,
    output logic cnt_nz
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, clean_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    db_state_e state, state_next;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
            state <= STABLE;
        end else begin
            s1    <= raw;
            s2    <= s1;
            clean <= clean_next;
            cnt   <= cnt_next;
            state <= state_next;
        end
    end
    // Acceptance happens on the edge where the counter already holds DEBOUNCE_CYCLES-1,
    // so the counter never has to represent DEBOUNCE_CYCLES itself.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = clean;
        changed    = 1'b0;
        if (state == STABLE) begin
            state_next = (s2 != clean) ? COUNTING : STABLE;
            cnt_next   = (s2 != clean) ? CNT_W'(1) : '0;
        end else if (s2 == clean) begin
            state_next = STABLE;
            cnt_next   = '0;
        end else if (cnt == LAST) begin
            state_next = STABLE;
            cnt_next   = '0;
            clean_next = s2;
            changed    = 1'b1;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end
    assign cnt_nz = (cnt_next != '0);
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: debounces four raw switches for Reg and issues a one-cycle load
// strobe whenever the debounced word changes.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [SW_W-1:0] sw_raw,
    output logic            sw1,
    output logic            sw2,
    output logic            sw3,
    output logic            sw4,
    output logic            enabling,
    output logic            busy
);
    logic [SW_W-1:0] clean, changed, cnt_nz;
    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_bit (
            .clock(clock),
            .reset_n(reset_n),
            .raw(sw_raw[i]),
            .clean(clean[i]),
            .changed(changed[i]),
            .cnt_nz(cnt_nz[i])
        );
    end
    assign {sw4, sw3, sw2, sw1} = clean;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enabling <= 1'b0;
            busy     <= 1'b0;
        end else begin
            enabling <= |changed;
            busy     <= |cnt_nz;
        end
    end
endmodule
